os_systolic_engine: RTL and testbench

Self-contained output-stationary GEMM engine: a ROWS×COLS grid of MAC cells with built-in input skew, a job sequencer, and a handshaked row-by-row result drain, so the external controller no longer hand-sequences load/drain strobes. It computes C = A·B for A (ROWS×K) and B (K×COLS), with K set per job, selectable signed/unsigned operands and a widened accumulator. It sits between the operand buffers (input stream) and the result writeback (output stream) in the accelerator datapath.

---
 rtl/os_systolic_engine_if.sv | 44 ++++
 rtl/os_systolic_engine.sv | 200 ++++++++++++++++++++
 tb/tb_os_systolic_engine.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/os_systolic_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : os_systolic_engine_if
// Brief    : Job control, operand input stream and result output stream of
//            the output-stationary systolic GEMM engine.
// Revision : 1.0
// ============================================================================
interface os_systolic_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int K_WIDTH    = 9
);
    localparam int c_row_idx_width = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                           start;
    logic [K_WIDTH-1:0]             k_len;
    logic                           is_signed;
    logic                           busy;
    logic                           done;

    logic                           in_valid;
    logic                           in_ready;
    logic [ROWS*DATA_WIDTH-1:0]     a_vec;
    logic [COLS*DATA_WIDTH-1:0]     b_vec;

    logic                           out_valid;
    logic                           out_ready;
    logic [COLS*ACC_WIDTH-1:0]      out_row;
    logic [c_row_idx_width-1:0]     out_row_idx;
    logic                           out_last;

    modport slave (
        input  start, k_len, is_signed, in_valid, a_vec, b_vec, out_ready,
        output busy, done, in_ready, out_valid, out_row, out_row_idx, out_last
    );

    modport master (
        output start, k_len, is_signed, in_valid, a_vec, b_vec, out_ready,
        input  busy, done, in_ready, out_valid, out_row, out_row_idx, out_last
    );
endinterface
`default_nettype wire

// File: rtl/os_systolic_engine.sv
`default_nettype none
// ============================================================================
// Module   : os_systolic_engine
// Brief    : ROWSxCOLS output-stationary MAC grid with input skew, job
//            sequencer and handshaked row-by-row result drain.
// Revision : 1.0
// ============================================================================
module os_systolic_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int K_WIDTH    = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    os_systolic_engine_if.slave  bus
);
    localparam int c_row_idx_width = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_flush_width   = (ROWS + COLS > 2) ? $clog2(ROWS + COLS) : 1;
    localparam logic [c_flush_width-1:0]   c_flush_last = c_flush_width'(ROWS + COLS - 2);
    localparam logic [c_row_idx_width-1:0] c_row_last   = c_row_idx_width'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [K_WIDTH-1:0]         r_k_len;
    logic [K_WIDTH-1:0]         r_beat_cnt;
    logic                       r_signed;
    logic [c_flush_width-1:0]   r_flush_cnt;
    logic [c_row_idx_width-1:0] r_row;
    logic                       r_done;

    logic w_start_ok, w_fire, w_last_beat, w_flush_end, w_row_accept, w_last_row;
    logic w_advance, w_clear, w_in_ready, w_out_valid;

    assign w_start_ok   = (r_state == S_IDLE) && bus.start && (bus.k_len != '0);
    assign w_fire       = (r_state == S_FEED) && bus.in_valid;
    assign w_last_beat  = w_fire && (r_beat_cnt == r_k_len - K_WIDTH'(1));
    assign w_flush_end  = (r_state == S_FLUSH) && (r_flush_cnt == c_flush_last);
    assign w_row_accept = (r_state == S_DRAIN) && bus.out_ready;
    assign w_last_row   = (r_row == c_row_last);
    assign w_advance    = (r_state == S_FEED) || (r_state == S_FLUSH);
    assign w_clear      = w_start_ok;

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_next = S_FEED;
            S_FEED: begin
                w_in_ready = 1'b1;
                if (w_last_beat) w_state_next = S_FLUSH;
            end
            S_FLUSH: if (w_flush_end) w_state_next = S_DRAIN;
            S_DRAIN: begin
                w_out_valid = 1'b1;
                if (w_row_accept && w_last_row) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_k_len     <= '0;
            r_signed    <= 1'b0;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
            r_row       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_row_accept && w_last_row;
            if (w_start_ok) begin
                r_k_len     <= bus.k_len;
                r_signed    <= bus.is_signed;
                r_beat_cnt  <= '0;
                r_flush_cnt <= '0;
                r_row       <= '0;
            end
            if (w_fire)             r_beat_cnt  <= r_beat_cnt + K_WIDTH'(1);
            if (r_state == S_FLUSH) r_flush_cnt <= r_flush_cnt + c_flush_width'(1);
            if (w_row_accept)       r_row       <= w_last_row ? '0 : r_row + c_row_idx_width'(1);
        end
    end

    // Operand inputs of every cell; column 0 / row 0 are fed by the skew lines.
    logic [DATA_WIDTH-1:0] w_a [ROWS][COLS];
    logic [DATA_WIDTH-1:0] w_b [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  w_acc [ROWS][COLS];

    // Bubbles inject zeros so an idle beat contributes nothing to any cell.
    genvar gi, gj;
    for (gi = 0; gi < ROWS; gi++) begin : g_a_skew
        logic [DATA_WIDTH-1:0] w_inj;
        assign w_inj = w_fire ? bus.a_vec[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (gi == 0) begin : g_direct
            assign w_a[gi][0] = w_inj;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] r_dly [gi];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < gi; k++) r_dly[k] <= '0;
                end else if (w_clear) begin
                    for (int k = 0; k < gi; k++) r_dly[k] <= '0;
                end else if (w_advance) begin
                    r_dly[0] <= w_inj;
                    for (int k = 1; k < gi; k++) r_dly[k] <= r_dly[k-1];
                end
            end
            assign w_a[gi][0] = r_dly[gi-1];
        end
    end

    for (gj = 0; gj < COLS; gj++) begin : g_b_skew
        logic [DATA_WIDTH-1:0] w_inj;
        assign w_inj = w_fire ? bus.b_vec[gj*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (gj == 0) begin : g_direct
            assign w_b[0][gj] = w_inj;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] r_dly [gj];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < gj; k++) r_dly[k] <= '0;
                end else if (w_clear) begin
                    for (int k = 0; k < gj; k++) r_dly[k] <= '0;
                end else if (w_advance) begin
                    r_dly[0] <= w_inj;
                    for (int k = 1; k < gj; k++) r_dly[k] <= r_dly[k-1];
                end
            end
            assign w_b[0][gj] = r_dly[gj-1];
        end
    end

    // Extending straight to ACC_WIDTH gives the same low bits as extending the
    // 2*DATA_WIDTH product, since that product never overflows its width.
    for (gi = 0; gi < ROWS; gi++) begin : g_row
        for (gj = 0; gj < COLS; gj++) begin : g_col
            logic [ACC_WIDTH-1:0] r_acc;
            logic [ACC_WIDTH-1:0] w_a_ext, w_b_ext, w_prod;
            assign w_a_ext = {{(ACC_WIDTH-DATA_WIDTH){r_signed & w_a[gi][gj][DATA_WIDTH-1]}}, w_a[gi][gj]};
            assign w_b_ext = {{(ACC_WIDTH-DATA_WIDTH){r_signed & w_b[gi][gj][DATA_WIDTH-1]}}, w_b[gi][gj]};
            assign w_prod  = w_a_ext * w_b_ext;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)         r_acc <= '0;
                else if (w_clear)   r_acc <= '0;
                else if (w_advance) r_acc <= r_acc + w_prod;
            end
            assign w_acc[gi][gj] = r_acc;

            if (gj < COLS - 1) begin : g_a_pass
                logic [DATA_WIDTH-1:0] r_a_pass;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)         r_a_pass <= '0;
                    else if (w_clear)   r_a_pass <= '0;
                    else if (w_advance) r_a_pass <= w_a[gi][gj];
                end
                assign w_a[gi][gj+1] = r_a_pass;
            end

            if (gi < ROWS - 1) begin : g_b_pass
                logic [DATA_WIDTH-1:0] r_b_pass;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)         r_b_pass <= '0;
                    else if (w_clear)   r_b_pass <= '0;
                    else if (w_advance) r_b_pass <= w_b[gi][gj];
                end
                assign w_b[gi+1][gj] = r_b_pass;
            end
        end
    end

    logic [COLS*ACC_WIDTH-1:0] w_out_row;
    always_comb begin
        w_out_row = '0;
        if (r_state == S_DRAIN) begin
            for (int j = 0; j < COLS; j++) w_out_row[j*ACC_WIDTH +: ACC_WIDTH] = w_acc[r_row][j];
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_row     = w_out_row;
    assign bus.out_row_idx = r_row;
    assign bus.out_last    = w_out_valid && w_last_row;
    assign bus.done        = r_done;
endmodule
`default_nettype wire

// File: tb/tb_os_systolic_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_os_systolic_engine
// Brief    : Self-checking bench for os_systolic_engine (vector table plus
//            scoreboard of expected result rows).
// Revision : 1.0
// ============================================================================
module tb_os_systolic_engine;
    localparam int DW    = 8;
    localparam int AW    = 32;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int KW    = 9;
    localparam int MAXK  = 256;
    localparam int LIMIT = 3000;

    typedef struct {
        int                   idx;
        logic [COLS*AW-1:0]   row;
        bit                   last;
    } row_t;

    typedef struct {
        int             k;
        bit             sgn;
        logic [DW-1:0]  av;
        logic [DW-1:0]  bv;
        logic [AW-1:0]  c;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    os_systolic_engine_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(ROWS), .COLS(COLS), .K_WIDTH(KW)) bus ();

    os_systolic_engine #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(ROWS), .COLS(COLS), .K_WIDTH(KW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    row_t sb[$];
    logic [DW-1:0] ma [ROWS][MAXK];
    logic [DW-1:0] mb [MAXK][COLS];
    vec_t vecs [4];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] outs_vec();
        return {22'd0, bus.busy, bus.in_ready, bus.out_valid, bus.out_last, bus.done,
                bus.out_row_idx, bus.out_row};
    endfunction

    function automatic logic [AW-1:0] model_c(input int i, input int j, input int k, input bit sgn);
        logic [AW-1:0] acc;
        longint        p;
        acc = '0;
        for (int t = 0; t < k; t++) begin
            if (sgn) p = longint'($signed(ma[i][t])) * longint'($signed(mb[t][j]));
            else     p = longint'(ma[i][t]) * longint'(mb[t][j]);
            acc = acc + p[AW-1:0];
        end
        return acc;
    endfunction

    task automatic push_model(input int k, input bit sgn);
        row_t e;
        for (int r = 0; r < ROWS; r++) begin
            e.idx = r; e.last = (r == ROWS-1); e.row = '0;
            for (int j = 0; j < COLS; j++) e.row[j*AW +: AW] = model_c(r, j, k, sgn);
            sb.push_back(e);
        end
    endtask

    task automatic push_const(input logic [AW-1:0] c);
        row_t e;
        for (int r = 0; r < ROWS; r++) begin
            e.idx = r; e.last = (r == ROWS-1);
            for (int j = 0; j < COLS; j++) e.row[j*AW +: AW] = c;
            sb.push_back(e);
        end
    endtask

    // A = I, B[k][j] = 4k+j+1, so C[r][j] = 4r+j+1.
    task automatic setup_identity();
        row_t e;
        for (int i = 0; i < ROWS; i++)
            for (int t = 0; t < 4; t++) ma[i][t] = (i == t) ? 8'd1 : 8'd0;
        for (int t = 0; t < 4; t++)
            for (int j = 0; j < COLS; j++) mb[t][j] = DW'(4*t + j + 1);
        for (int r = 0; r < ROWS; r++) begin
            e.idx = r; e.last = (r == ROWS-1);
            for (int j = 0; j < COLS; j++) e.row[j*AW +: AW] = AW'(4*r + j + 1);
            sb.push_back(e);
        end
    endtask

    task automatic fill_random(input int k);
        for (int t = 0; t < k; t++) begin
            for (int i = 0; i < ROWS; i++) ma[i][t] = DW'($urandom);
            for (int j = 0; j < COLS; j++) mb[t][j] = DW'($urandom);
        end
    endtask

    task automatic begin_job(input int k, input bit sgn);
        cyc = 0;
        bus.start = 1'b1; bus.k_len = KW'(k); bus.is_signed = sgn;
        step();
        bus.start = 1'b0; bus.is_signed = ~sgn; bus.k_len = KW'($urandom);
        check("busy_after_start", 160'(bus.busy), 160'(1));
    endtask

    task automatic feed(input int n, input int pct, input int poke);
        int beat = 0;
        int guard = 0;
        bit v, rdy;
        while (beat < n && guard < LIMIT) begin
            v = (pct >= 100) || ($urandom_range(0, 99) < pct);
            bus.in_valid = v;
            for (int i = 0; i < ROWS; i++) bus.a_vec[i*DW +: DW] = v ? ma[i][beat] : DW'($urandom);
            for (int j = 0; j < COLS; j++) bus.b_vec[j*DW +: DW] = v ? mb[beat][j] : DW'($urandom);
            bus.start = (beat == poke);
            if (beat == poke) bus.k_len = KW'(3);
            rdy = bus.in_ready;
            step();
            if (v && rdy) beat++;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check("feed_timeout", 160'(guard >= LIMIT), 160'(0));
    endtask

    task automatic drain(input int bp_row, input int bp_len, output int first_lat, output int done_lat);
        int   guard = 0;
        int   stall = 0;
        bit   done_early = 1'b0;
        logic [159:0] held;
        row_t e;
        first_lat = -1;
        held = '0;
        while (sb.size() > 0 && guard < LIMIT) begin
            if (bus.done) done_early = 1'b1;
            if (bus.out_valid) begin
                if (first_lat < 0) first_lat = cyc;
                if (int'(bus.out_row_idx) == bp_row && stall < bp_len) begin
                    if (stall == 0) held = outs_vec();
                    else check("hold_stable", outs_vec(), held);
                    stall++;
                    bus.out_ready = 1'b0;
                end else begin
                    e = sb.pop_front();
                    check("row_idx",  160'(bus.out_row_idx), 160'(e.idx));
                    check("row_data", 160'(bus.out_row), 160'(e.row));
                    check("row_last", 160'(bus.out_last), 160'(e.last));
                    bus.out_ready = 1'b1;
                end
            end else begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end
            step();
            guard++;
        end
        bus.out_ready = 1'b1;
        check("drain_timeout", 160'(guard >= LIMIT), 160'(0));
        check("done_early", 160'(done_early), 160'(0));
        check("done_busy_valid", 160'({bus.done, bus.busy, bus.out_valid}), 160'(3'b100));
        done_lat = cyc;
        sb.delete();
    endtask

    task automatic run_job(input int k, input bit sgn, input int pct, input int poke,
                           input int bp_row, input int bp_len, output int first_lat, output int done_lat);
        begin_job(k, sgn);
        feed(k, pct, poke);
        check("in_ready_low_flush", 160'(bus.in_ready), 160'(0));
        drain(bp_row, bp_len, first_lat, done_lat);
    endtask

    task automatic reset_pulse(input string name);
        bit saw_done = 1'b0;
        #2 rst_n = 1'b0;
        #1 check(name, outs_vec(), '0);
        step();
        step();
        rst_n = 1'b1;
        repeat (3) begin
            step();
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        check("no_done_after_reset", 160'(saw_done), 160'(0));
    endtask

    initial begin
        int fl, dl, guard;
        vecs[0] = '{256, 1'b1, 8'h80, 8'h80, 32'd4194304};
        vecs[1] = '{256, 1'b0, 8'h80, 8'h80, 32'd4194304};
        vecs[2] = '{256, 1'b1, 8'hFF, 8'hFF, 32'd256};
        vecs[3] = '{256, 1'b0, 8'hFF, 8'hFF, 32'd16646400};

        bus.start = 1'b0; bus.k_len = '0; bus.is_signed = 1'b0; bus.in_valid = 1'b0;
        bus.a_vec = '0; bus.b_vec = '0; bus.out_ready = 1'b1;
        step();
        check("reset_outputs", outs_vec(), '0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_outputs", outs_vec(), '0);

        // Identity job, continuous input, no backpressure.
        setup_identity();
        run_job(4, 1'b0, 100, -1, -1, 0, fl, dl);
        check("first_valid_latency", 160'(fl), 160'(12));
        check("done_latency", 160'(dl), 160'(16));

        // Sign/width table; each job starts the cycle after the previous done.
        for (int v = 0; v < 4; v++) begin
            step();
            for (int t = 0; t < vecs[v].k; t++) begin
                for (int i = 0; i < ROWS; i++) ma[i][t] = vecs[v].av;
                for (int j = 0; j < COLS; j++) mb[t][j] = vecs[v].bv;
            end
            push_const(vecs[v].c);
            run_job(vecs[v].k, vecs[v].sgn, 100, -1, -1, 0, fl, dl);
        end

        // Back-to-back identity after large accumulations.
        step();
        setup_identity();
        run_job(4, 1'b0, 100, -1, -1, 0, fl, dl);

        // Random signed 4x4x37 with bubbles, then the same job continuous.
        step();
        fill_random(37);
        push_model(37, 1'b1);
        run_job(37, 1'b1, 40, -1, -1, 0, fl, dl);
        step();
        push_model(37, 1'b1);
        run_job(37, 1'b1, 100, -1, -1, 0, fl, dl);

        // Backpressure on row 1 for five cycles.
        step();
        setup_identity();
        run_job(4, 1'b0, 100, -1, 1, 5, fl, dl);
        check("bp_done_latency", 160'(dl), 160'(21));

        // start with k_len = 0 is ignored.
        step();
        bus.start = 1'b1; bus.k_len = '0;
        step();
        bus.start = 1'b0;
        check("klen0_busy", 160'({bus.busy, bus.in_ready}), 160'(0));
        step();
        check("klen0_busy_later", 160'({bus.busy, bus.in_ready}), 160'(0));

        // start pulsed during FEED does not disturb the running job.
        fill_random(9);
        push_model(9, 1'b0);
        run_job(9, 1'b0, 100, 3, -1, 0, fl, dl);

        // Reset mid-FEED, then a clean identity job.
        step();
        setup_identity();
        sb.delete();
        begin_job(4, 1'b0);
        feed(2, 100, -1);
        reset_pulse("rst_mid_feed_outputs");
        setup_identity();
        run_job(4, 1'b0, 100, -1, -1, 0, fl, dl);
        check("post_reset_done_latency", 160'(dl), 160'(16));

        // Reset mid-DRAIN after one row is accepted, then identity again.
        step();
        setup_identity();
        sb.delete();
        begin_job(4, 1'b0);
        feed(4, 100, -1);
        bus.out_ready = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < LIMIT) begin
            step();
            guard++;
        end
        check("drain_wait_timeout", 160'(guard >= LIMIT), 160'(0));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("mid_drain_row", 160'(bus.out_row_idx), 160'(1));
        reset_pulse("rst_mid_drain_outputs");
        bus.out_ready = 1'b1;
        setup_identity();
        run_job(4, 1'b0, 100, -1, -1, 0, fl, dl);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
